// File: rtl/dt_cls_filter_if.sv
// Classifier-side sample input, stable-class status and stable-change event port
// of the temporal confirmation filter.
interface dt_cls_filter_if #(
  parameter int C = 3
);
  logic         in_valid;
  logic [C-1:0] in_cls;
  logic         stable_valid;
  logic [C-1:0] stable_cls;
  logic         evt_valid;
  logic         evt_ready;
  logic [C-1:0] evt_cls;
  logic [C-1:0] evt_prev;
  logic [7:0]   drop_cnt;
  logic [7:0]   invalid_cnt;

  modport master (
    output in_valid, in_cls, evt_ready,
    input  stable_valid, stable_cls, evt_valid, evt_cls, evt_prev, drop_cnt, invalid_cnt
  );

  modport slave (
    input  in_valid, in_cls, evt_ready,
    output stable_valid, stable_cls, evt_valid, evt_cls, evt_prev, drop_cnt, invalid_cnt
  );
endinterface

// File: rtl/dt_cls_filter.sv
// Temporal confirmation filter: a class becomes stable after CONFIRM consecutive
// identical valid samples; each stable change is offered once on a valid/ready port.
module dt_cls_filter #(
  parameter int C       = 3,
  parameter int MAX_CLS = 5,
  parameter int CONFIRM = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dt_cls_filter_if.slave bus
);
  localparam int           RW      = $clog2(CONFIRM + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(CONFIRM);
  localparam logic [C-1:0]  MAX_C   = C'(MAX_CLS);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_t;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  lock_t         lock_reg, lock_next;
  slot_t         slot_reg, slot_next;
  logic [C-1:0]  cand_reg, cand_next;
  logic [RW-1:0] run_reg, run_next;
  logic [C-1:0]  stable_cls_reg, stable_cls_next;
  logic [C-1:0]  evt_cls_reg, evt_cls_next;
  logic [C-1:0]  evt_prev_reg, evt_prev_next;
  logic [7:0]    drop_cnt_reg, drop_cnt_next;
  logic [7:0]    invalid_cnt_reg, invalid_cnt_next;
  logic          sample_ok, sample_bad, confirm;

  assign sample_ok  = bus.in_valid && (bus.in_cls <= MAX_C);
  assign sample_bad = bus.in_valid && (bus.in_cls > MAX_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg        <= UNLOCKED;
      slot_reg        <= EMPTY;
      cand_reg        <= '0;
      run_reg         <= '0;
      stable_cls_reg  <= '0;
      evt_cls_reg     <= '0;
      evt_prev_reg    <= '0;
      drop_cnt_reg    <= '0;
      invalid_cnt_reg <= '0;
    end else begin
      lock_reg        <= lock_next;
      slot_reg        <= slot_next;
      cand_reg        <= cand_next;
      run_reg         <= run_next;
      stable_cls_reg  <= stable_cls_next;
      evt_cls_reg     <= evt_cls_next;
      evt_prev_reg    <= evt_prev_next;
      drop_cnt_reg    <= drop_cnt_next;
      invalid_cnt_reg <= invalid_cnt_next;
    end
  end

  always_comb begin
    lock_next        = lock_reg;
    slot_next        = slot_reg;
    cand_next        = cand_reg;
    run_next         = run_reg;
    stable_cls_next  = stable_cls_reg;
    evt_cls_next     = evt_cls_reg;
    evt_prev_next    = evt_prev_reg;
    drop_cnt_next    = drop_cnt_reg;
    invalid_cnt_next = invalid_cnt_reg;
    confirm          = 1'b0;

    if (sample_ok) begin
      if (bus.in_cls == cand_reg && run_reg != '0) begin
        run_next = (run_reg == RUN_MAX) ? run_reg : run_reg + RW'(1);
      end else begin
        cand_next = bus.in_cls;
        run_next  = RW'(1);
      end
    end else if (sample_bad) begin
      run_next = '0;
      if (invalid_cnt_reg != 8'hFF) invalid_cnt_next = invalid_cnt_reg + 8'd1;
    end

    // Only a valid sample can complete a run; a held full run matches stable_cls.
    confirm = sample_ok && (run_next == RUN_MAX) &&
              (lock_reg == UNLOCKED || cand_next != stable_cls_reg);

    if (confirm) begin
      lock_next       = LOCKED;
      stable_cls_next = cand_next;
      evt_cls_next    = cand_next;
      evt_prev_next   = stable_cls_reg;
      slot_next       = FULL;
      if (slot_reg == FULL && !bus.evt_ready && drop_cnt_reg != 8'hFF)
        drop_cnt_next = drop_cnt_reg + 8'd1;
    end else if (slot_reg == FULL && bus.evt_ready) begin
      slot_next = EMPTY;
    end
  end

  assign bus.stable_valid = (lock_reg == LOCKED);
  assign bus.stable_cls   = stable_cls_reg;
  assign bus.evt_valid    = (slot_reg == FULL);
  assign bus.evt_cls      = evt_cls_reg;
  assign bus.evt_prev     = evt_prev_reg;
  assign bus.drop_cnt     = drop_cnt_reg;
  assign bus.invalid_cnt  = invalid_cnt_reg;
endmodule
